// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the post-conv pooling stage: FSM encodings, region bases
// and the DRAM address packing used by both the source and destination maps.
package relu_maxpool_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3
  } state_e;

  localparam int SRC_BASE_DEF = 131072;
  localparam int DST_BASE_DEF = 196608;

  localparam int PAD_BITS  = 4;
  localparam int CH_BITS   = 4;
  localparam int Y_BITS    = 5;
  localparam int X_BITS    = 5;
  localparam int PACK_BITS = PAD_BITS + CH_BITS + Y_BITS + X_BITS;

  // Word offset of element (c, y, x) inside a region.
  function automatic logic [PACK_BITS-1:0] packAddr(
    input logic [CH_BITS-1:0] c,
    input logic [Y_BITS-1:0]  y,
    input logic [X_BITS-1:0]  x
  );
    return {{PAD_BITS{1'b0}}, c, y, x};
  endfunction

endpackage

// File: rtl/relu_maxpool_smax2.sv
// Combinational signed two-input maximum; ties return the shared value.
module smax2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0] max_o
);

  assign max_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/relu_maxpool.sv
// 2x2/stride-2 max pooling over a Q16.16 ofmap in DRAM, writing the next layer's ifmap.
// Define POOL_RELU_EN to clamp negative pooled results to zero before they are written.
module relu_maxpool
  import relu_maxpool_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 18,
  parameter int FMAP_WIDTH  = 10,
  parameter int FMAP_HEIGHT = 10,
  parameter int FMAP_DEPTH  = 16,
  parameter int SRC_BASE    = SRC_BASE_DEF,
  parameter int DST_BASE    = DST_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic                  dram_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam logic [X_BITS-1:0]  LAST_PX = X_BITS'(FMAP_WIDTH / 2 - 1);
  localparam logic [Y_BITS-1:0]  LAST_PY = Y_BITS'(FMAP_HEIGHT / 2 - 1);
  localparam logic [CH_BITS-1:0] LAST_C  = CH_BITS'(FMAP_DEPTH - 1);

  state_e                       state_q, stateDly_q;
  logic [1:0]                   win_q, winDly_q;
  logic [X_BITS-1:0]            px_q, px_d;
  logic [Y_BITS-1:0]            py_q, py_d;
  logic [CH_BITS-1:0]           c_q, c_d;
  logic signed [DATA_WIDTH-1:0] runMax_q;
  logic signed [DATA_WIDTH-1:0] maxOut;
  logic signed [DATA_WIDTH-1:0] poolVal;
  logic                         done_q;
  logic                         lastWin;
  logic                         unusedValid;

  assign unusedValid = dram_valid;

  // Running max and final max both fold the incoming word into the register.
  smax2 #(.DATA_WIDTH(DATA_WIDTH)) uMax (
    .a_i  (runMax_q),
    .b_i  (data_in),
    .max_o(maxOut)
  );

  assign lastWin = (px_q == LAST_PX) && (py_q == LAST_PY) && (c_q == LAST_C);

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    c_d  = c_q;
    if (px_q == LAST_PX) begin
      px_d = '0;
      if (py_q == LAST_PY) begin
        py_d = '0;
        c_d  = (c_q == LAST_C) ? '0 : c_q + 1'b1;
      end else begin
        py_d = py_q + 1'b1;
      end
    end else begin
      px_d = px_q + 1'b1;
    end
  end

  // The delayed state/window tag each read response, which lands one cycle after its request.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= ST_IDLE;
      stateDly_q <= ST_IDLE;
      win_q      <= '0;
      winDly_q   <= '0;
      px_q       <= '0;
      py_q       <= '0;
      c_q        <= '0;
      runMax_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      stateDly_q <= state_q;
      winDly_q   <= win_q;
      done_q     <= 1'b0;
      if (stateDly_q == ST_RD) begin
        runMax_q <= (winDly_q == 2'd0) ? data_in : maxOut;
      end
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_RD;
        end
        ST_RD: begin
          win_q <= win_q + 2'd1;
          if (win_q == 2'd3) state_q <= ST_WR;
        end
        ST_WR: begin
          px_q    <= px_d;
          py_q    <= py_d;
          c_q     <= c_d;
          state_q <= lastWin ? ST_DONE : ST_RD;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef POOL_RELU_EN
  assign poolVal = maxOut[DATA_WIDTH-1] ? '0 : maxOut;
`else
  assign poolVal = maxOut;
`endif

  assign dram_en_rd = (state_q == ST_RD);
  assign dram_en_wr = (state_q == ST_WR);
  assign done       = done_q;

  assign addr_in  = dram_en_rd
                  ? ADDR_WIDTH'(SRC_BASE) + ADDR_WIDTH'(packAddr(c_q,
                      {py_q[Y_BITS-2:0], win_q[1]}, {px_q[X_BITS-2:0], win_q[0]}))
                  : '0;
  assign addr_out = dram_en_wr
                  ? ADDR_WIDTH'(DST_BASE) + ADDR_WIDTH'(packAddr(c_q, py_q, px_q))
                  : '0;
  assign data_out = dram_en_wr ? poolVal : '0;

endmodule

// File: tb/tb_relu_maxpool.sv
// Directed bench for relu_maxpool: hand-computed windows, full ramp, re-pulse and mid-run reset.
module tb_relu_maxpool;

  localparam int SRC = 131072;
  localparam int DST = 196608;
`ifdef POOL_RELU_EN
  localparam logic [31:0] NEG_EXP = 32'h00000000;
`else
  localparam logic [31:0] NEG_EXP = 32'hFFFF0000;
`endif

  logic        clk = 1'b0;
  logic        srstn, enable, dram_valid;
  logic [31:0] data_in, data_out;
  logic [17:0] addr_in, addr_out;
  logic        dram_en_rd, dram_en_wr, done;

  int checks = 0;
  int errors = 0;

  logic [17:0] wrAddr[$];
  logic [31:0] wrData[$];
  logic [17:0] rdAddr[$];
  int          doneCount, doneCycle;

  relu_maxpool dut (
    .clk       (clk),
    .srstn     (srstn),
    .enable    (enable),
    .dram_valid(dram_valid),
    .data_in   (data_in),
    .data_out  (data_out),
    .addr_in   (addr_in),
    .addr_out  (addr_out),
    .dram_en_rd(dram_en_rd),
    .dram_en_wr(dram_en_wr),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Source map is a ramp (value = address) except the two hand-built windows.
  function automatic logic [31:0] memRead(input logic [17:0] a);
    case (a)
      18'd131072: return 32'h00030000;
      18'd131073: return 32'hFFFF0000;
      18'd131104: return 32'h00070000;
      18'd131105: return 32'h00020000;
      18'd131074: return 32'hFFFF0000;
      18'd131075: return 32'hFFFE0000;
      18'd131106: return 32'hFFFD0000;
      18'd131107: return 32'hFFFC0000;
      default:    return {14'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (dram_en_rd) data_in <= memRead(addr_in);
  end

  function automatic logic [31:0] expData(input int i);
    int px = i % 5;
    int py = (i / 5) % 5;
    int c  = i / 25;
    if (i == 0) return 32'h00070000;
    if (i == 1) return NEG_EXP;
    return SRC + c * 1024 + (2 * py + 1) * 32 + 2 * px + 1;
  endfunction

  function automatic logic [17:0] expWrAddr(input int i);
    return DST + (i / 25) * 1024 + ((i / 5) % 5) * 32 + (i % 5);
  endfunction

  function automatic logic [17:0] expRdAddr(input int j);
    int w   = j / 4;
    int win = j % 4;
    return SRC + (w / 25) * 1024 + (2 * ((w / 5) % 5) + win / 2) * 32
               + 2 * (w % 5) + win % 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, data_out, 0);
    checkOutput({tag, "_addr_in"}, addr_in, 0);
    checkOutput({tag, "_addr_out"}, addr_out, 0);
    checkOutput({tag, "_rd"}, dram_en_rd, 0);
    checkOutput({tag, "_wr"}, dram_en_wr, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  // cyc counts rising edges since the one that sampled enable.
  task automatic applyStimulus(input int repulseAt, input int resetAt);
    wrAddr.delete();
    wrData.delete();
    rdAddr.delete();
    doneCount = 0;
    doneCycle = -1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int cyc = 0; cyc <= 2100; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (dram_en_rd) rdAddr.push_back(addr_in);
      if (dram_en_wr) begin
        wrAddr.push_back(addr_out);
        wrData.push_back(data_out);
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = cyc;
      end
      if (resetAt >= 0 && cyc == resetAt + 1) begin
        checkAllZero("afterReset");
        srstn = 1'b1;
        break;
      end
      enable = (cyc == repulseAt);
      srstn  = (cyc != resetAt);
    end
    enable = 1'b0;
    srstn  = 1'b1;
  endtask

  task automatic verifyRun(input string tag);
    int badW = 0;
    int badR = 0;
    for (int i = 0; i < wrAddr.size(); i++) begin
      if (wrAddr[i] !== expWrAddr(i) || wrData[i] !== expData(i)) badW++;
    end
    for (int j = 0; j < rdAddr.size(); j++) begin
      if (rdAddr[j] !== expRdAddr(j)) badR++;
    end
    checkOutput({tag, "_writes"}, wrAddr.size(), 400);
    checkOutput({tag, "_reads"}, rdAddr.size(), 1600);
    checkOutput({tag, "_badWrites"}, badW, 0);
    checkOutput({tag, "_badReads"}, badR, 0);
    checkOutput({tag, "_doneCount"}, doneCount, 1);
    checkOutput({tag, "_doneCycle"}, doneCycle, 2001);
  endtask

  initial begin
    int activity;
    srstn      = 1'b0;
    enable     = 1'b0;
    dram_valid = 1'b0;
    data_in    = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    srstn = 1'b1;
    @(negedge clk);
    checkAllZero("idle");

    $display("[TB] full pass with hand-built windows");
    applyStimulus(-1, -1);
    verifyRun("runA");
    checkOutput("win0_addr", wrAddr[0], 196608);
    checkOutput("win0_data", wrData[0], 32'h00070000);
    checkOutput("win1_addr", wrAddr[1], 196609);
    checkOutput("win1_negData", wrData[1], NEG_EXP);
    checkOutput("last_addr", wrAddr[399], 212100);
    checkOutput("w58_rd0", rdAddr[232], 133190);
    checkOutput("w58_rd1", rdAddr[233], 133191);
    checkOutput("w58_rd2", rdAddr[234], 133222);
    checkOutput("w58_rd3", rdAddr[235], 133223);
    checkOutput("w58_wr", wrAddr[58], 198691);

    $display("[TB] enable re-pulsed mid-run");
    applyStimulus(600, -1);
    verifyRun("runB");

    $display("[TB] reset during window 37");
    applyStimulus(-1, 187);
    checkOutput("partialWrites", wrAddr.size(), 37);
    activity = 0;
    repeat (10) begin
      @(negedge clk);
      if (dram_en_rd || dram_en_wr || done) activity++;
    end
    checkOutput("idleAfterReset", activity, 0);
    applyStimulus(-1, -1);
    checkOutput("restart_rd0", rdAddr[0], 131072);
    verifyRun("runC");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
